// File: rtl/press_decoder.sv
// Classifies conditioned button presses into short, long and double events.
// A single counter times both the press length and the release-to-repress gap.
module press_decoder #(
  parameter int LONG_CYCLES = 50,
  parameter int DOUBLE_GAP  = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic conditioned,
  input  logic positiveedge,
  input  logic negativeedge,
  output logic shortpress,
  output logic longpress,
  output logic doublepress,
  output logic held
);

  localparam int MAX_COUNT = (LONG_CYCLES > DOUBLE_GAP) ? LONG_CYCLES : DOUBLE_GAP;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    GAP,
    PRESSED2,
    HELD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             shortpress_q, shortpress_d;
  logic             longpress_q, longpress_d;
  logic             doublepress_q, doublepress_d;
  logic             held_q, held_d;

  logic             pos_ok;
  logic             neg_ok;
  logic [CNT_W-1:0] count_inc;

  // Coincident edge pulses cancel each other out in every state.
  assign pos_ok    = positiveedge & ~negativeedge;
  assign neg_ok    = negativeedge & ~positiveedge;
  assign count_inc = (count_q == '1) ? count_q : count_q + CNT_ONE;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shortpress_d  = 1'b0;
    longpress_d   = 1'b0;
    doublepress_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A genuine rising edge leaves the level high; this also keeps a
        // button held through reset from being mistaken for a new press.
        if (pos_ok && conditioned) begin
          state_d = PRESSED;
          count_d = CNT_ONE;
        end
      end
      PRESSED: begin
        if (neg_ok) begin
          state_d = GAP;
          count_d = CNT_ONE;
        end else if (count_q == LONG_LAST) begin
          state_d     = HELD;
          count_d     = count_inc;
          longpress_d = 1'b1;
        end else begin
          count_d = count_inc;
        end
      end
      GAP: begin
        if (pos_ok) begin
          state_d       = PRESSED2;
          doublepress_d = 1'b1;
        end else if (count_q == GAP_LAST) begin
          state_d      = IDLE;
          count_d      = '0;
          shortpress_d = 1'b1;
        end else begin
          count_d = count_inc;
        end
      end
      PRESSED2, HELD: begin
        if (neg_ok) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    held_d = (state_d == HELD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      shortpress_q  <= 1'b0;
      longpress_q   <= 1'b0;
      doublepress_q <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      shortpress_q  <= shortpress_d;
      longpress_q   <= longpress_d;
      doublepress_q <= doublepress_d;
      held_q        <= held_d;
    end
  end

  assign shortpress  = shortpress_q;
  assign longpress   = longpress_q;
  assign doublepress = doublepress_q;
  assign held        = held_q;

endmodule

// File: tb/tb_press_decoder.sv
// Directed bench for press_decoder: a timestamp-based event model is compared
// every cycle, plus hand-computed latencies and levels at key points.
module tb_press_decoder;

  localparam int LONG = 50;
  localparam int GAPC = 25;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic conditioned = 1'b0;
  logic positiveedge = 1'b0;
  logic negativeedge = 1'b0;
  logic shortpress, longpress, doublepress, held;

  int checks = 0;
  int errors = 0;

  press_decoder #(.LONG_CYCLES(LONG), .DOUBLE_GAP(GAPC)) dut (
    .clk(clk),
    .reset(reset),
    .conditioned(conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge),
    .shortpress(shortpress),
    .longpress(longpress),
    .doublepress(doublepress),
    .held(held)
  );

  always #10 clk = ~clk;

  // Model: remembers when the press started / was released and what kind of
  // interval the button is in, then derives each event from elapsed cycles.
  int  cyc = 0;
  int  t_start = 0;
  int  t_rel = 0;
  int  phase = 0;  // 0 waiting, 1 first press, 2 released, 3 second press, 4 long hold
  logic exp_short = 1'b0, exp_long = 1'b0, exp_dbl = 1'b0;
  logic exp_held;
  logic pe, ne;

  assign pe       = positiveedge && !negativeedge;
  assign ne       = negativeedge && !positiveedge;
  assign exp_held = (phase == 4);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= 0;
      exp_short <= 1'b0;
      exp_long  <= 1'b0;
      exp_dbl   <= 1'b0;
    end else begin
      exp_short <= 1'b0;
      exp_long  <= 1'b0;
      exp_dbl   <= 1'b0;
      case (phase)
        0: if (pe && conditioned) begin phase <= 1; t_start <= cyc; end
        1: begin
          if (ne) begin phase <= 2; t_rel <= cyc; end
          else if (cyc - t_start + 1 == LONG) begin phase <= 4; exp_long <= 1'b1; end
        end
        2: begin
          if (pe) begin phase <= 3; exp_dbl <= 1'b1; end
          else if (cyc - t_rel + 1 == GAPC) begin phase <= 0; exp_short <= 1'b1; end
        end
        3, 4: if (ne) phase <= 0;
        default: phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_short", int'(shortpress), int'(exp_short));
      chk("model_long", int'(longpress), int'(exp_long));
      chk("model_double", int'(doublepress), int'(exp_dbl));
      chk("model_held", int'(held), int'(exp_held));
      chk("one_pulse_max", int'(shortpress) + int'(longpress) + int'(doublepress) <= 1, 1);
    end
  end

  function automatic logic sel(input int w);
    case (w)
      0: return shortpress;
      1: return longpress;
      default: return doublepress;
    endcase
  endfunction

  task automatic wait_out(input int which, input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (sel(which)) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pos();
    positiveedge = 1'b1;
    conditioned  = 1'b1;
    @(negedge clk);
    positiveedge = 1'b0;
  endtask

  task automatic pulse_neg();
    negativeedge = 1'b1;
    conditioned  = 1'b0;
    @(negedge clk);
    negativeedge = 1'b0;
  endtask

  int k;

  initial begin
    #5;
    chk("reset_outputs", int'({shortpress, longpress, doublepress, held}), 0);
    idle(3);
    reset = 1'b0;
    idle(2);

    // Short press held 10 cycles.
    pulse_pos();
    idle(9);
    pulse_neg();
    wait_out(0, 40, k);
    chk("short_latency", k, 24);
    idle(30);

    // Long press held 60 cycles.
    pulse_pos();
    wait_out(1, 60, k);
    chk("long_latency", k, 49);
    chk("held_after_long", int'(held), 1);
    idle(10);
    pulse_neg();
    chk("held_after_release", int'(held), 0);
    idle(40);

    // Double press, second press held 80 cycles.
    pulse_pos();
    idle(4);
    pulse_neg();
    idle(9);
    pulse_pos();
    chk("double_at_repress", int'(doublepress), 1);
    idle(80);
    pulse_neg();
    idle(40);

    // Re-press at gap count 24: still a double press.
    pulse_pos();
    idle(4);
    pulse_neg();
    idle(23);
    pulse_pos();
    chk("double_gap24", int'(doublepress), 1);
    pulse_neg();
    idle(40);

    // Re-press at gap count 25: short press, then a fresh first press.
    pulse_pos();
    idle(4);
    pulse_neg();
    idle(24);
    chk("short_gap25", int'(shortpress), 1);
    pulse_pos();
    chk("no_double_gap25", int'(doublepress), 0);
    idle(3);
    pulse_neg();
    wait_out(0, 40, k);
    chk("short_after_gap25", k, 24);
    idle(30);

    // Asynchronous reset 30 cycles into a long press, button still down.
    pulse_pos();
    idle(29);
    #3 reset = 1'b1;
    #1 chk("async_reset_outputs", int'({shortpress, longpress, doublepress, held}), 0);
    idle(3);
    reset = 1'b0;
    idle(5);
    chk("no_event_after_reset", int'({shortpress, longpress, doublepress, held}), 0);
    pulse_neg();
    idle(40);
    pulse_pos();
    idle(9);
    pulse_neg();
    wait_out(0, 40, k);
    chk("short_after_reset", k, 24);
    idle(30);

    // Glitches in IDLE: coincident edges, then a stray falling edge.
    positiveedge = 1'b1;
    negativeedge = 1'b1;
    @(negedge clk);
    positiveedge = 1'b0;
    negativeedge = 1'b0;
    idle(5);
    pulse_neg();
    idle(30);

    // Coincident edges during a press are ignored; the press still times out short.
    pulse_pos();
    idle(2);
    positiveedge = 1'b1;
    negativeedge = 1'b1;
    @(negedge clk);
    positiveedge = 1'b0;
    negativeedge = 1'b0;
    idle(3);
    pulse_neg();
    wait_out(0, 40, k);
    chk("short_after_coincident", k, 24);
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
